// File: rtl/button_debouncer.sv
// Two-channel push-button conditioner for the snake game core.
// Each raw key is polarity-normalised, passed through a 2-FF synchroniser
// and debounced by a saturating hold counter. The block outputs the clean
// levels, a one-cycle pulse per accepted press, and a busy flag. An optional
// chord lockout keeps a simultaneous right+left press from producing a turn pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_BIT         = 18,
    parameter int ACTIVE_LOW      = 1,
    parameter int LOCKOUT         = 1
) (
    input  logic clock_25,
    input  logic reset,
    input  logic key_right,
    input  logic key_left,
    output logic right_P,
    output logic left_P,
    output logic right_press,
    output logic left_press,
    output logic busy
);

    // Channel index 0 is right, 1 is left throughout.
    localparam logic               INV     = (ACTIVE_LOW != 0);
    localparam logic               LOCK_EN = (LOCKOUT != 0);
    localparam logic [CNT_BIT-1:0] CNT_MAX = CNT_BIT'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         w_key_norm;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_stable;
    logic [1:0]         r_press;
    logic [CNT_BIT-1:0] r_cnt [2];
    logic [1:0]         w_accept;
    logic [1:0]         w_rise;
    logic [1:0]         w_press_next;

    // Pressed reads as 1 after normalisation, whatever the board polarity.
    assign w_key_norm = {key_left, key_right} ^ {2{INV}};

    // Two-flop synchroniser; reset loads the released value so that
    // leaving reset can never look like a press edge.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_key_norm;
            r_sync2 <= r_sync1;
        end
    end

    // Decide which channels accept a new level this edge, which of those are
    // presses, and whether the lockout swallows the press pulse.
    always_comb begin
        w_accept     = 2'b00;
        w_rise       = 2'b00;
        w_press_next = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
            w_rise[i]   = w_accept[i] & r_sync2[i];
        end
        if (LOCK_EN) begin
            // Suppress if the other side is already held or rises on this edge.
            w_press_next[0] = w_rise[0] & ~(r_stable[1] | w_rise[1]);
            w_press_next[1] = w_rise[1] & ~(r_stable[0] | w_rise[0]);
        end else begin
            w_press_next = w_rise;
        end
    end

    // Debounce: a differing level must survive DEBOUNCE_CYCLES consecutive
    // edges; any return to the stable value restarts the count from zero.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_stable <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press pulse register, high for the first cycle of the new level only.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_press <= 2'b00;
        end else begin
            r_press <= w_press_next;
        end
    end

    assign right_P     = r_stable[0];
    assign left_P      = r_stable[1];
    assign right_press = r_press[0];
    assign left_press  = r_press[1];
    // Derived only from counter registers, so no path from the raw keys.
    assign busy        = (r_cnt[0] != '0) | (r_cnt[1] != '0);

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with DEBOUNCE_CYCLES=4, active-low keys.
// A lockout instance and a no-lockout instance share the same key stimulus.
module tb_button_debouncer;

    logic clock_25 = 1'b0;
    logic reset    = 1'b1;
    logic key_right = 1'b1;
    logic key_left  = 1'b1;

    logic right_P, left_P, right_press, left_press, busy;
    logic nl_right_P, nl_left_P, nl_right_press, nl_left_press, nl_busy;

    int checks = 0;
    int errors = 0;

    // Clock and reset block: 10 ns period; reset is driven by the vector table.
    always #5 clock_25 = ~clock_25;

    button_debouncer #(
        .DEBOUNCE_CYCLES(4), .CNT_BIT(3), .ACTIVE_LOW(1), .LOCKOUT(1)
    ) dut (
        .clock_25(clock_25), .reset(reset),
        .key_right(key_right), .key_left(key_left),
        .right_P(right_P), .left_P(left_P),
        .right_press(right_press), .left_press(left_press),
        .busy(busy)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(4), .CNT_BIT(3), .ACTIVE_LOW(1), .LOCKOUT(0)
    ) dut_nl (
        .clock_25(clock_25), .reset(reset),
        .key_right(key_right), .key_left(key_left),
        .right_P(nl_right_P), .left_P(nl_left_P),
        .right_press(nl_right_press), .left_press(nl_left_press),
        .busy(nl_busy)
    );

    // One segment: hold inputs for n edges, then expect the final levels/busy
    // and the number of press pulses seen on each instance during the segment.
    typedef struct {
        logic rst;
        logic kr;
        logic kl;
        int   n;
        logic rp;
        logic lp;
        logic bsy;
        int   rpc;
        int   lpc;
        int   nrpc;
        int   nlpc;
    } vec_t;

    vec_t vecs[25];
    vec_t exp_q[$];

    int cnt_rp, cnt_lp, cnt_nrp, cnt_nlp;

    function automatic vec_t mk(logic rst, logic kr, logic kl, int n,
                                logic rp, logic lp, logic bsy,
                                int rpc, int lpc, int nrpc, int nlpc);
        vec_t v;
        v.rst = rst; v.kr = kr; v.kl = kl; v.n = n;
        v.rp = rp; v.lp = lp; v.bsy = bsy;
        v.rpc = rpc; v.lpc = lpc; v.nrpc = nrpc; v.nlpc = nlpc;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Driver: apply a segment's inputs and count pulses over its edges.
    task automatic drive_vec(input vec_t v);
        reset     = v.rst;
        key_right = v.kr;
        key_left  = v.kl;
        cnt_rp = 0; cnt_lp = 0; cnt_nrp = 0; cnt_nlp = 0;
        repeat (v.n) begin
            @(posedge clock_25);
            #1;
            cnt_rp  += int'(right_press);
            cnt_lp  += int'(left_press);
            cnt_nrp += int'(nl_right_press);
            cnt_nlp += int'(nl_left_press);
        end
    endtask

    // Scoreboard: pop the expectation pushed when the segment was driven.
    task automatic score_vec(input int idx);
        vec_t e;
        e = exp_q.pop_front();
        check_bit($sformatf("row%0d right_P", idx), right_P, e.rp);
        check_bit($sformatf("row%0d left_P", idx), left_P, e.lp);
        check_bit($sformatf("row%0d busy", idx), busy, e.bsy);
        check_bit($sformatf("row%0d nl_right_P", idx), nl_right_P, e.rp);
        check_bit($sformatf("row%0d nl_left_P", idx), nl_left_P, e.lp);
        check_int($sformatf("row%0d right_press_count", idx), cnt_rp, e.rpc);
        check_int($sformatf("row%0d left_press_count", idx), cnt_lp, e.lpc);
        check_int($sformatf("row%0d nl_right_press_count", idx), cnt_nrp, e.nrpc);
        check_int($sformatf("row%0d nl_left_press_count", idx), cnt_nlp, e.nlpc);
    endtask

    initial begin
        // Keys: 1 = released, 0 = pressed. A change becomes visible on the
        // 6th edge after it is applied.
        //                  rst kr  kl  n   rP  lP  bsy rpc lpc nrpc nlpc
        vecs[0]  = mk(1'b1, 1'b1, 1'b1,  3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // reset, keys released
        vecs[1]  = mk(1'b0, 1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // idle
        vecs[2]  = mk(1'b0, 1'b0, 1'b1,  5, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0); // right press, edges 1..5
        vecs[3]  = mk(1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0); // edge 6: level + pulse
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 20, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0); // long hold, no repeat
        vecs[5]  = mk(1'b0, 1'b1, 1'b1,  5, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0); // release edges 1..5
        vecs[6]  = mk(1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // edge 6: falls, no pulse
        vecs[7]  = mk(1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // bounce 0
        vecs[8]  = mk(1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // bounce 1
        vecs[9]  = mk(1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0); // bounce 0 (count starts)
        vecs[10] = mk(1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // bounce 1 (count cleared)
        vecs[11] = mk(1'b0, 1'b0, 1'b1,  5, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0); // settle low, edges 1..5
        vecs[12] = mk(1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0); // edge 6 after last bounce
        vecs[13] = mk(1'b0, 1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // release
        vecs[14] = mk(1'b0, 1'b0, 1'b0,  6, 1'b1, 1'b1, 1'b0, 0, 0, 1, 1); // chord: no pulses w/ lockout
        vecs[15] = mk(1'b0, 1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // release both
        vecs[16] = mk(1'b0, 1'b1, 1'b0,  6, 1'b0, 1'b1, 1'b0, 0, 1, 0, 1); // left alone pulses
        vecs[17] = mk(1'b0, 1'b0, 1'b0,  6, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0); // right while left held
        vecs[18] = mk(1'b0, 1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // release both
        vecs[19] = mk(1'b0, 1'b0, 1'b1,  4, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0); // right press, cnt=2
        vecs[20] = mk(1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // reset mid-count
        vecs[21] = mk(1'b0, 1'b0, 1'b1,  5, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0); // held through reset
        vecs[22] = mk(1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0); // fresh press after reset
        vecs[23] = mk(1'b0, 1'b0, 1'b0,  6, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1); // left while right held
        vecs[24] = mk(1'b0, 1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0); // release both

        for (int i = 0; i < 25; i++) begin
            exp_q.push_back(vecs[i]);
            drive_vec(vecs[i]);
            score_vec(i);
        end

        // Hand sequence: left press edge by edge; level and pulse appear
        // together on edge 6, pulse lasts exactly one cycle.
        key_left = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock_25);
            #1;
            check_bit($sformatf("seq_left edge%0d left_P", k), left_P, (k >= 6));
            check_bit($sformatf("seq_left edge%0d left_press", k), left_press, (k == 6));
            check_bit($sformatf("seq_left edge%0d right_press", k), right_press, 1'b0);
        end

        // Hand sequence: release edge by edge; falls on edge 6, no pulse.
        key_left = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock_25);
            #1;
            check_bit($sformatf("seq_rel edge%0d left_P", k), left_P, (k < 6));
            check_bit($sformatf("seq_rel edge%0d left_press", k), left_press, 1'b0);
            check_bit($sformatf("seq_rel edge%0d busy", k), busy, (k >= 3 && k <= 5));
        end

        check_int("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
